// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage sequencer: FSM state encoding,
// sizing helpers, bit reversal and the default read+butterfly latency.
package fft_pkg;

  localparam int unsigned BFLY_LAT    = 4;
  localparam int unsigned DEFAULT_LAT = 1 + BFLY_LAT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } fft_state_t;

  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned fft_logn(input int unsigned n);
    return clog2_u(n);
  endfunction

  // Stage counter width: max(1, clog2(LOGN)).
  function automatic int unsigned stage_width(input int unsigned logn);
    int unsigned w;
    w = clog2_u(logn);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[5'(i)] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Enable-gated shift register of parameterised width and depth with
// synchronous clear; depth must be at least 1.
module fft_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT control sequencer: per-stage butterfly read/twiddle/write
// addressing with ping-pong banks. FFT_SEQ_BITREV_EN bit-reverses stage-0 reads.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter  int unsigned N    = 8,
  parameter  int unsigned LAT  = DEFAULT_LAT,
  localparam int unsigned LOGN = fft_logn(N),
  localparam int unsigned SW   = stage_width(LOGN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic            i_start,
  output logic            o_rd_en,
  output logic [LOGN-1:0] o_rd_addr_even,
  output logic [LOGN-1:0] o_rd_addr_odd,
  output logic            o_rd_bank,
  output logic [LOGN-2:0] o_twi_idx,
  output logic            o_wr_en,
  output logic [LOGN-1:0] o_wr_addr_top,
  output logic [LOGN-1:0] o_wr_addr_bot,
  output logic            o_wr_bank,
  output logic [SW-1:0]   o_stage,
  output logic            o_busy,
  output logic            o_done
);

  localparam int unsigned JW  = LOGN - 1;
  localparam int unsigned DW  = (clog2_u(LAT) == 0) ? 1 : clog2_u(LAT);
  localparam int unsigned DLW = 2 * LOGN + 2;

  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [DW-1:0] D_LAST = DW'(LAT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

  fft_state_t      state_q, state_d;
  logic [JW-1:0]   j_q, j_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            issue;

  logic [LOGN-1:0] j_ext, half, mask;
  logic [LOGN-1:0] even_nat, odd_nat, even_rd, odd_rd;
  logic [SW-1:0]   shamt;
  logic [JW-1:0]   twi_nxt;

  logic            rd_valid_q;
  logic [LOGN-1:0] rd_even_q, rd_odd_q, wr_even_q, wr_odd_q;
  logic [JW-1:0]   rd_twi_q;
  logic            rd_bank_q, wr_bank_q;

  logic [DLW-1:0]  dl_in, dl_out;
  logic            wr_valid;

  assign issue = (state_q == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      stage_q <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (i_en) begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // DRAIN lasts exactly LAT enabled cycles, so the next stage's first read
  // lands on the edge after the previous stage's last write.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    dcnt_d  = dcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RUN;
          j_d     = '0;
          stage_d = '0;
          dcnt_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        j_d = j_q + 1'b1;
        if (j_q == J_LAST) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == D_LAST) begin
          if (stage_q == S_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            stage_d = stage_q + 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // even = ((j>>s)<<(s+1)) + pos is rewritten as ((j & ~mask) << 1) | pos.
  always_comb begin
    j_ext    = LOGN'(j_q);
    half     = LOGN'(1) << stage_q;
    mask     = half - LOGN'(1);
    even_nat = ((j_ext & ~mask) << 1) | (j_ext & mask);
    odd_nat  = even_nat | half;
    shamt    = S_LAST - stage_q;
    twi_nxt  = j_q << shamt;
`ifdef FFT_SEQ_BITREV_EN
    if (stage_q == '0) begin
      even_rd = LOGN'(bit_rev(32'(even_nat), LOGN));
      odd_rd  = LOGN'(bit_rev(32'(odd_nat), LOGN));
    end else begin
      even_rd = even_nat;
      odd_rd  = odd_nat;
    end
`else
    even_rd = even_nat;
    odd_rd  = odd_nat;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_even_q  <= '0;
      rd_odd_q   <= '0;
      rd_twi_q   <= '0;
      rd_bank_q  <= 1'b0;
      wr_even_q  <= '0;
      wr_odd_q   <= '0;
      wr_bank_q  <= 1'b0;
    end else if (i_en) begin
      rd_valid_q <= issue;
      if (issue) begin
        rd_even_q <= even_rd;
        rd_odd_q  <= odd_rd;
        rd_twi_q  <= twi_nxt;
        rd_bank_q <= stage_q[0];
        wr_even_q <= even_nat;
        wr_odd_q  <= odd_nat;
        wr_bank_q <= ~stage_q[0];
      end
    end
  end

  assign dl_in = {rd_valid_q, wr_even_q, wr_odd_q, wr_bank_q};

  fft_delay_line #(
    .WIDTH(DLW),
    .DEPTH(LAT)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .en  (i_en),
    .din (dl_in),
    .dout(dl_out)
  );

  assign {wr_valid, o_wr_addr_top, o_wr_addr_bot, o_wr_bank} = dl_out;

  assign o_rd_en        = rd_valid_q & i_en;
  assign o_rd_addr_even = rd_even_q;
  assign o_rd_addr_odd  = rd_odd_q;
  assign o_rd_bank      = rd_bank_q;
  assign o_twi_idx      = rd_twi_q;
  assign o_wr_en        = wr_valid & i_en;
  assign o_stage        = stage_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer (N=8, LAT=5): stimulus queues
// expected reads/writes/done with their enabled-cycle times; a monitor pops them.
module tb_fft_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst, i_en, i_start;
  logic       o_rd_en, o_rd_bank, o_wr_en, o_wr_bank, o_busy, o_done;
  logic [2:0] o_rd_addr_even, o_rd_addr_odd, o_wr_addr_top, o_wr_addr_bot;
  logic [1:0] o_twi_idx, o_stage;
  logic [21:0] all_out;

  always #5 clk = ~clk;

  fft_stage_sequencer #(.N(8), .LAT(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (i_en),
    .i_start       (i_start),
    .o_rd_en       (o_rd_en),
    .o_rd_addr_even(o_rd_addr_even),
    .o_rd_addr_odd (o_rd_addr_odd),
    .o_rd_bank     (o_rd_bank),
    .o_twi_idx     (o_twi_idx),
    .o_wr_en       (o_wr_en),
    .o_wr_addr_top (o_wr_addr_top),
    .o_wr_addr_bot (o_wr_addr_bot),
    .o_wr_bank     (o_wr_bank),
    .o_stage       (o_stage),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  assign all_out = {o_rd_en, o_rd_addr_even, o_rd_addr_odd, o_rd_bank, o_twi_idx,
                    o_wr_en, o_wr_addr_top, o_wr_addr_bot, o_wr_bank, o_stage, o_busy, o_done};

  typedef struct {
    int unsigned t;
    int unsigned a;
    int unsigned b;
    int unsigned k;
    int unsigned bank;
    int unsigned stg;
  } ev_t;

  typedef struct {
    int unsigned t;
    int unsigned c;
  } dn_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  dn_t done_q[$];

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned en_cyc = 0;

  // Hand-computed butterfly tables, index = stage*4 + j.
  int unsigned nat_even [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int unsigned nat_odd  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int unsigned twi_tab  [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
`ifdef FFT_SEQ_BITREV_EN
  int unsigned rd_even_t[12] = '{0, 2, 1, 3, 0, 1, 4, 5, 0, 1, 2, 3};
  int unsigned rd_odd_t [12] = '{4, 6, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
`else
  int unsigned rd_even_t[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int unsigned rd_odd_t [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
`endif

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i_en && !rst) en_cyc <= en_cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // e0/c0: enabled/absolute cycle count just after the start edge.
  task automatic push_run(input int unsigned e0, input int unsigned c0,
                          input int unsigned lim, input int unsigned stall_n);
    ev_t e;
    dn_t d;
    int unsigned k;
    int unsigned tr;
    for (int unsigned s = 0; s < 3; s++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        k  = s * 4 + j;
        tr = e0 + 1 + s * 9 + j;
        if (tr <= lim) begin
          e.t = tr; e.a = rd_even_t[k]; e.b = rd_odd_t[k]; e.k = twi_tab[k];
          e.bank = s % 2; e.stg = s;
          rd_q.push_back(e);
        end
        if (tr + 5 <= lim) begin
          e.t = tr + 5; e.a = nat_even[k]; e.b = nat_odd[k]; e.k = 0;
          e.bank = 1 - (s % 2); e.stg = 0;
          wr_q.push_back(e);
        end
      end
    end
    if (e0 + 28 <= lim) begin
      d.t = e0 + 28;
      d.c = c0 + 28 + stall_n;
      done_q.push_back(d);
    end
  endtask

  task automatic start_run(output int unsigned e0, output int unsigned c0);
    i_start = 1'b1;
    i_en    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    e0 = en_cyc;
    c0 = cyc;
  endtask

  task automatic wait_drain(input string name);
    int unsigned n;
    n = 0;
    while ((rd_q.size() + wr_q.size() + done_q.size()) != 0 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (6) begin @(posedge clk); #1; end
    chk(name, 32'(rd_q.size() + wr_q.size() + done_q.size()), 0);
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    dn_t d;
    if (o_rd_en) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'(o_rd_en), 0);
      else begin
        e = rd_q.pop_front();
        chk("rd_time", en_cyc, e.t);
        chk("rd_even", 32'(o_rd_addr_even), e.a);
        chk("rd_odd", 32'(o_rd_addr_odd), e.b);
        chk("rd_twi", 32'(o_twi_idx), e.k);
        chk("rd_bank", 32'(o_rd_bank), e.bank);
        chk("rd_stage", 32'(o_stage), e.stg);
      end
    end
    if (o_wr_en) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 32'(o_wr_en), 0);
      else begin
        e = wr_q.pop_front();
        chk("wr_time", en_cyc, e.t);
        chk("wr_top", 32'(o_wr_addr_top), e.a);
        chk("wr_bot", 32'(o_wr_addr_bot), e.b);
        chk("wr_bank", 32'(o_wr_bank), e.bank);
      end
    end
    if (o_done) begin
      if (done_q.size() == 0) chk("done_unexpected", 32'(o_done), 0);
      else begin
        d = done_q.pop_front();
        chk("done_en_time", en_cyc, d.t);
        chk("done_abs_time", cyc, d.c);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0, c0;
    logic [13:0] hold_exp;

    rst = 1'b1; i_en = 1'b0; i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", 32'(all_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Start with i_en low must not be latched.
    i_start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    i_start = 1'b0; i_en = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("idle_no_start_busy", 32'(o_busy), 0);
    @(posedge clk); #1;

    // Full run; a start pulse during RUN must be ignored.
    start_run(e0, c0);
    push_run(e0, c0, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    chk("busy_on_entry", 32'(o_busy), 1);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (23) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("busy_before_done", 32'(o_busy), 1);
    chk("done_before_edge28", 32'(o_done), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_after_done", 32'(o_busy), 0);
    @(posedge clk); #1;
    wait_drain("run1_drain");

    // Three-cycle i_en stall in stage 1 after read (1,3) k2.
    start_run(e0, c0);
    push_run(e0, c0, 32'hFFFF_FFFF, 3);
    repeat (11) begin @(posedge clk); #1; end
    i_en = 1'b0;
    hold_exp = {1'b0, 1'b0, 3'd1, 3'd3, 2'd2, 1'b1, 2'd1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", 32'({o_rd_en, o_wr_en, o_rd_addr_even, o_rd_addr_odd,
                             o_twi_idx, o_rd_bank, o_stage, o_busy}), 32'(hold_exp));
      @(posedge clk);
    end
    #1;
    i_en = 1'b1;
    wait_drain("stall_drain");

    // Reset during stage-0 drain: in-flight writes discarded.
    start_run(e0, c0);
    push_run(e0, c0, e0 + 6, 0);
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mid_run_outputs", 32'(all_out), 0);
    @(posedge clk); #1;
    wait_drain("reset_drain");

    // Fresh run after the abort.
    start_run(e0, c0);
    push_run(e0, c0, 32'hFFFF_FFFF, 0);
    wait_drain("rerun_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Control sequencer that drives the radix-2 DIT butterfly datapath for an N-point FFT. It steps through all log2(N) stages and, per stage, emits one butterfly per enabled cycle: even/odd read addresses, twiddle index and ping-pong bank select. It also emits matching write addresses delayed by the read-plus-butterfly pipeline latency, and waits for the pipeline to drain between stages.

## Interface
- N, 8: FFT length, power of two, N ≥ 4; LOGN = log2(N).
- LAT, 5: cycles from read issue to butterfly result (1 sample-memory read + 4 butterfly).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_en  in  1  global pipeline advance; the same signal drives the butterfly enable.
- i_start  in  1  start request; accepted only in IDLE with i_en high.
- o_rd_en  out  1  read strobe = rd_valid & i_en.
- o_rd_addr_even  out  LOGN  even-input sample address.
- o_rd_addr_odd  out  LOGN  odd-input sample address.
- o_rd_bank  out  1  bank read this stage.
- o_twi_idx  out  LOGN-1  k in W_N^k for the twiddle ROM.
- o_wr_en  out  1  write strobe = wr_valid & i_en.
- o_wr_addr_top  out  LOGN  destination for the top output.
- o_wr_addr_bot  out  LOGN  destination for the bottom output.
- o_wr_bank  out  1  bank written.
- o_stage  out  max(1,clog2(LOGN))  current stage.
- o_busy  out  1  high from RUN entry until the last write.
- o_done  out  1  one-cycle pulse after the final write.

## Operation
- FSM: IDLE → RUN on i_start & i_en; RUN → DRAIN after butterfly j = N/2-1 issues; DRAIN → RUN (stage+1, j=0) once the stage's last write is presented, or → DONE if stage = LOGN-1; DONE → IDLE unconditionally.
- Stage s, butterfly j: half = 2^s, pos = j & (half-1), even = ((j>>s) << (s+1)) + pos, odd = even + half, twi = pos << (LOGN-1-s).
- Write addresses are always top = even, bot = odd (natural order).
- Banks: o_rd_bank = s[0]; writes go to the opposite bank. The final result lands in bank LOGN mod 2.
- Delay line: {valid, even, odd, wr_bank} is shifted LAT deep, advancing only when i_en is high. Its output is wr_valid and the o_wr_* fields.
- i_en low: FSM, counters and delay line freeze. o_rd_en and o_wr_en are forced low; all other outputs hold.
- i_start while busy is ignored. i_start in IDLE with i_en low is ignored (not latched).
- Reset values: FSM IDLE; all counters 0; delay line cleared. Every output is 0 (o_rd_bank 0, o_wr_bank 0, o_stage 0, o_busy 0, o_done 0).
- rst mid-operation returns the block to reset state within one edge. In-flight writes are discarded and no o_wr_en follows.

## Timing
- All outputs are registered except the i_en gating on o_rd_en and o_wr_en.
- Start sampled at edge t0 → first read visible after edge t0+1. Reads follow on consecutive enabled edges.
- A read visible after edge e has its write visible after edge e+LAT (enabled edges only).
- Stage period = N/2 + LAT enabled cycles. The next stage's first read is visible the edge after the previous stage's last write.
- o_done is visible after edge t0 + 1 + LOGN·(N/2+LAT). o_busy falls on that same edge.
- Total run = LOGN·(N/2+LAT)+1 enabled cycles.

## Configuration
- FFT_SEQ_BITREV_EN defined: stage 0 read addresses are bit-reversed (rev(even), rev(odd)), so input is loaded in natural order. Write addresses are unchanged.
- Undefined: stage 0 reads natural addresses; input must be pre-stored bit-reversed.

## Structure
- Shared package fft_pkg holds:
  - the state encoding (IDLE, RUN, DRAIN, DONE);
  - the bit-reverse function;
  - the LOGN/clog2 helper functions;
  - the default LAT constant, equal to 1 plus the butterfly latency.
- Sub-module fft_delay_line: parameterised width and depth, enable-gated shift register, synchronous clear.

## Test plan
- N=8, LAT=5, macro off, i_en=1, start at edge 0:
  - stage 0 reads (0,1),(2,3),(4,5),(6,7), twi 0;
  - stage 1 reads (0,2)k0,(1,3)k2,(4,6)k0,(5,7)k2;
  - stage 2 reads (0,4)k0,(1,5)k1,(2,6)k2,(3,7)k3;
  - o_done after edge 28.
- Same run: each o_wr_addr pair equals the read pair issued 5 edges earlier. o_rd_bank goes 0,1,0 and o_wr_bank goes 1,0,1. No read of stage s+1 occurs before the last write of stage s.
- Macro on: stage 0 reads (0,4),(2,6),(1,5),(3,7); writes (0,1),(2,3),(4,5),(6,7).
- i_en low for 3 cycles mid stage 1: outputs hold, o_rd_en and o_wr_en are 0, the sequence resumes unchanged, and o_done slips exactly 3 cycles.
- rst asserted during DRAIN of stage 0: next edge all outputs are 0 and no o_wr_en follows. A new start then produces the full sequence from stage 0.
- i_start pulsed during RUN: ignored, single o_done pulse. i_start with i_en low in IDLE: no run.
